// File: rtl/interleave_split.sv
// Splits an interleaved (x, y) sample stream into two lockstep output FIFOs,
// left-shifting every sample by QUANT_BITS on the way through.
module interleave_split #(
  parameter int DATA_SIZE  = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 in_rd_en,
  input  logic                 in_empty,
  input  logic [DATA_SIZE-1:0] din,
  output logic                 x_out_wr_en,
  output logic                 y_out_wr_en,
  input  logic                 x_out_full,
  input  logic                 y_out_full,
  output logic [DATA_SIZE-1:0] x_dout,
  output logic [DATA_SIZE-1:0] y_dout,
  output logic [31:0]          pair_count
);

  typedef enum logic [1:0] {
    READ_X = 2'd0,
    READ_Y = 2'd1,
    WRITE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_SIZE-1:0]   x_q, x_d;
  logic [DATA_SIZE-1:0]   y_q, y_d;
  logic [31:0]            pair_count_q, pair_count_d;
  logic [DATA_SIZE-1:0]   din_quant;

  // Left shift keeps the low DATA_SIZE bits: overflow wraps, LSBs fill with zero.
  assign din_quant = din << QUANT_BITS;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pair_count_d = pair_count_q;
    in_rd_en     = 1'b0;
    x_out_wr_en  = 1'b0;
    y_out_wr_en  = 1'b0;

    case (state_q)
      READ_X: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          x_d      = din_quant;
          state_d  = READ_Y;
        end
      end
      READ_Y: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          y_d      = din_quant;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        // Both sides or neither, so downstream heads stay pair-aligned.
        if (!x_out_full && !y_out_full) begin
          x_out_wr_en  = 1'b1;
          y_out_wr_en  = 1'b1;
          pair_count_d = pair_count_q + 32'd1;
          state_d      = READ_X;
        end
      end
      default: state_d = READ_X;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= READ_X;
      x_q          <= '0;
      y_q          <= '0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign x_dout     = x_q;
  assign y_dout     = y_q;
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_interleave_split.sv
// Directed bench for interleave_split: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_interleave_split;

  localparam int DS = 32;
  localparam int QB = 10;
  localparam int N_PAIRS = 1000;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_rd_en;
  logic          in_empty;
  logic [DS-1:0] din;
  logic          x_out_wr_en, y_out_wr_en;
  logic          x_out_full, y_out_full;
  logic [DS-1:0] x_dout, y_dout;
  logic [31:0]   pair_count;

  int checks = 0;
  int errors = 0;

  interleave_split #(.DATA_SIZE(DS), .QUANT_BITS(QB)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_rd_en    (in_rd_en),
    .in_empty    (in_empty),
    .din         (din),
    .x_out_wr_en (x_out_wr_en),
    .y_out_wr_en (y_out_wr_en),
    .x_out_full  (x_out_full),
    .y_out_full  (y_out_full),
    .x_dout      (x_dout),
    .y_dout      (y_dout),
    .pair_count  (pair_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DS-1:0] quant(input logic [DS-1:0] v);
    return v << QB;
  endfunction

  // Move to the next falling edge; the caller then sets inputs and waits #1.
  task automatic step();
    @(negedge clock);
  endtask

  // One unstalled pair: pop x, pop y, write. Expected outputs are hand values.
  task automatic run_pair(input string tag, input logic [31:0] xin, input logic [31:0] yin,
                          input logic [31:0] xexp, input logic [31:0] yexp);
    step(); in_empty = 1'b0; din = xin; #1;
    check({tag, "_rd_x"}, {31'd0, in_rd_en}, 32'd1);
    step(); din = yin; #1;
    check({tag, "_rd_y"}, {31'd0, in_rd_en}, 32'd1);
    step(); in_empty = 1'b1; din = '0; #1;
    check({tag, "_wr_x"}, {31'd0, x_out_wr_en}, 32'd1);
    check({tag, "_wr_y"}, {31'd0, y_out_wr_en}, 32'd1);
    check({tag, "_x"}, x_dout, xexp);
    check({tag, "_y"}, y_dout, yexp);
  endtask

  logic [DS-1:0] samples[2*N_PAIRS];
  int            idx, written, cycles;

  initial begin
    reset = 1'b1; in_empty = 1'b1; din = '0; x_out_full = 1'b0; y_out_full = 1'b0;
    #2;
    check("rst_x", x_dout, 32'd0);
    check("rst_y", y_dout, 32'd0);
    check("rst_cnt", pair_count, 32'd0);
    check("rst_strobes", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);
    step(); reset = 1'b0;

    // Basic split: 3, -2 -> 3072, -2048, strobes on the third cycle.
    run_pair("basic", 32'd3, 32'hFFFF_FFFE, 32'h0000_0C00, 32'hFFFF_F800);
    check("basic_cnt_before", pair_count, 32'd0);
    step(); #1;
    check("basic_cnt", pair_count, 32'd1);
    check("basic_idle", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);

    // Lockstep back-pressure on y, input word available throughout.
    y_out_full = 1'b1;
    step(); in_empty = 1'b0; din = 32'd1; #1;
    step(); din = 32'd2; #1;
    for (int i = 0; i < 5; i++) begin
      step(); din = 32'd99; #1;
      check("bp_stall_strobes", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);
    end
    // Full releases in the same cycle the input goes empty.
    step(); y_out_full = 1'b0; in_empty = 1'b1; #1;
    check("bp_release_wr", {30'd0, x_out_wr_en, y_out_wr_en}, 32'd3);
    check("bp_x", x_dout, 32'h0000_0400);
    check("bp_y", y_dout, 32'h0000_0800);
    step(); #1;
    check("bp_wait_read_x", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);
    check("bp_cnt", pair_count, 32'd2);

    // Starved mid-pair: x popped, then four empty cycles in READ_Y.
    in_empty = 1'b0; din = 32'd4; #1;
    check("starve_rd_x", {31'd0, in_rd_en}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); in_empty = 1'b1; #1;
      check("starve_hold", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);
      check("starve_x_held", x_dout, 32'h0000_1000);
      check("starve_y_prev", y_dout, 32'h0000_0800);
    end
    step(); in_empty = 1'b0; din = 32'd6; #1;
    check("starve_rd_y", {31'd0, in_rd_en}, 32'd1);
    step(); in_empty = 1'b1; #1;
    check("starve_wr", {30'd0, x_out_wr_en, y_out_wr_en}, 32'd3);
    check("starve_x", x_dout, 32'h0000_1000);
    check("starve_y", y_dout, 32'h0000_1800);

    // Quantize wrap cases.
    run_pair("wrap1", 32'h0040_0000, 32'h001F_FFFF, 32'h0000_0000, 32'h7FFF_FC00);
    run_pair("wrap2", 32'h8000_0001, 32'h0000_0000, 32'h0000_0400, 32'h0000_0000);
    step(); #1;
    check("wrap_cnt", pair_count, 32'd5);

    // Reset after the x pop discards the half pair.
    in_empty = 1'b0; din = 32'd9; #1;
    step(); in_empty = 1'b1; reset = 1'b1; #1;
    check("mid_rst_x", x_dout, 32'd0);
    check("mid_rst_y", y_dout, 32'd0);
    check("mid_rst_cnt", pair_count, 32'd0);
    check("mid_rst_strobes", {29'd0, in_rd_en, x_out_wr_en, y_out_wr_en}, 32'd0);
    step(); reset = 1'b0;
    run_pair("post_rst", 32'd5, 32'd7, 32'd5120, 32'd7168);
    step(); #1;
    check("post_rst_cnt", pair_count, 32'd1);

    // Streaming with random empty/full toggling against a de-interleaved model.
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 2*N_PAIRS; i++) samples[i] = $urandom;
    idx = 0; written = 0; cycles = 0;
    while (written < N_PAIRS && cycles < 30000) begin
      step();
      in_empty   = (idx >= 2*N_PAIRS) || ($urandom_range(0, 3) == 0);
      din        = (idx < 2*N_PAIRS) ? samples[idx] : '0;
      x_out_full = ($urandom_range(0, 3) == 0);
      y_out_full = ($urandom_range(0, 3) == 0);
      #1;
      check("stream_lockstep", {31'd0, x_out_wr_en}, {31'd0, y_out_wr_en});
      check("stream_rd_while_empty", {31'd0, in_rd_en & in_empty}, 32'd0);
      check("stream_wr_while_full", {31'd0, x_out_wr_en & (x_out_full | y_out_full)}, 32'd0);
      if (in_rd_en && !in_empty) idx++;
      if (x_out_wr_en) begin
        check("stream_x", x_dout, quant(samples[2*written]));
        check("stream_y", y_dout, quant(samples[2*written+1]));
        written++;
      end
      cycles++;
    end
    step(); in_empty = 1'b1; x_out_full = 1'b0; y_out_full = 1'b0; #1;
    check("stream_pairs_written", written, N_PAIRS);
    check("stream_words_popped", idx, 2*N_PAIRS);
    check("stream_cnt", pair_count, N_PAIRS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
